// File: rtl/trap_controller.sv
// Trap entry / trap return sequencer: picks one event in IDLE, then flushes the pipeline,
// commits CSR/privilege state and redirects fetch through a ready handshake.
`ifndef XLEN
`define XLEN 32
`endif

module trap_controller #(
  parameter int unsigned XLEN = `XLEN
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            exc_valid,
  input  logic [4:0]      exc_code,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_val,
  input  logic            irq_pending,
  input  logic [4:0]      irq_code,
  input  logic [XLEN-1:0] irq_pc,
  input  logic            xret_valid,
  input  logic            xret_is_mret,
  input  logic [1:0]      current_priv,
  input  logic [15:0]     medeleg,
  input  logic [15:0]     mideleg,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] stvec,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] sepc,
  input  logic [1:0]      mpp,
  input  logic            spp,
  input  logic            redirect_ready,
  output logic            busy,
  output logic            pipe_stall,
  output logic            pipe_flush,
  output logic            trap_csr_we,
  output logic            xret_csr_we,
  output logic            trap_to_s,
  output logic [XLEN-1:0] trap_cause,
  output logic [XLEN-1:0] trap_epc,
  output logic [XLEN-1:0] trap_tval,
  output logic            priv_we,
  output logic [1:0]      priv_next,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_is_xret;
  logic [XLEN-1:0] r_target;

  logic            w_evt;
  logic            w_is_irq;
  logic            w_is_xret;
  logic [4:0]      w_code;
  logic [15:0]     w_deleg;
  logic            w_to_s;
  logic [XLEN-1:0] w_tvec;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_cause;
  logic [XLEN-1:0] w_epc;
  logic [XLEN-1:0] w_tval;
  logic [1:0]      w_priv;

  // Decode the highest-priority event and everything the sequence will need from it
  always_comb begin
    w_evt     = exc_valid | irq_pending | xret_valid;
    w_is_irq  = !exc_valid && irq_pending;
    w_is_xret = !exc_valid && !irq_pending && xret_valid;
    w_code    = exc_valid ? exc_code : irq_code;
    w_deleg   = exc_valid ? medeleg : mideleg;
    w_to_s    = (current_priv != PRIV_M) && !w_code[4] && w_deleg[w_code[3:0]];
    w_cause   = XLEN'(w_code);
    w_epc     = exc_pc;
    w_tval    = exc_val;
    w_priv    = PRIV_M;

    if (w_is_irq) begin
      w_cause = (XLEN'(1) << (XLEN - 1)) | XLEN'(w_code);
      w_epc   = irq_pc;
      w_tval  = '0;
    end

    if (w_is_xret) begin
      w_to_s  = !xret_is_mret;
      w_cause = '0;
      w_epc   = '0;
      w_tval  = '0;
    end

    w_tvec = w_to_s ? stvec : mtvec;
    w_base = {w_tvec[XLEN-1:2], 2'b00};
    // Only interrupts honour vectored mode
    if (w_is_irq && (w_tvec[1:0] == 2'b01)) begin
      w_target = w_base + (XLEN'(w_code) << 2);
    end else begin
      w_target = w_base;
    end

    if (w_is_xret) begin
      if (xret_is_mret) begin
        w_target = {mepc[XLEN-1:1], 1'b0};
        w_priv   = mpp;
      end else begin
        w_target = {sepc[XLEN-1:1], 1'b0};
        w_priv   = {1'b0, spp};
      end
    end else begin
      w_priv = w_to_s ? PRIV_S : PRIV_M;
    end
  end

  // Sequencer with all outputs registered from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_is_xret      <= 1'b0;
      r_target       <= '0;
      busy           <= 1'b0;
      pipe_stall     <= 1'b0;
      pipe_flush     <= 1'b0;
      trap_csr_we    <= 1'b0;
      xret_csr_we    <= 1'b0;
      trap_to_s      <= 1'b0;
      trap_cause     <= '0;
      trap_epc       <= '0;
      trap_tval      <= '0;
      priv_we        <= 1'b0;
      priv_next      <= PRIV_M;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      pipe_flush  <= 1'b0;
      trap_csr_we <= 1'b0;
      xret_csr_we <= 1'b0;
      priv_we     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_evt) begin
            r_state    <= ST_FLUSH;
            r_is_xret  <= w_is_xret;
            r_target   <= w_target;
            busy       <= 1'b1;
            pipe_stall <= 1'b1;
            pipe_flush <= 1'b1;
            trap_to_s  <= w_to_s;
            trap_cause <= w_cause;
            trap_epc   <= w_epc;
            trap_tval  <= w_tval;
            priv_next  <= w_priv;
          end
        end
        ST_FLUSH: begin
          r_state     <= ST_COMMIT;
          priv_we     <= 1'b1;
          trap_csr_we <= !r_is_xret;
          xret_csr_we <= r_is_xret;
        end
        ST_COMMIT: begin
          r_state        <= ST_REDIRECT;
          redirect_valid <= 1'b1;
          redirect_pc    <= r_target;
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            r_state        <= ST_IDLE;
            redirect_valid <= 1'b0;
            busy           <= 1'b0;
            pipe_stall     <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Directed testbench for trap_controller (RV32): trap entry, delegation, vectoring,
// priority, returns, redirect back-pressure and mid-sequence reset.
`timescale 1ns/1ps

module tb_trap_controller;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            exc_valid;
  logic [4:0]      exc_code;
  logic [XLEN-1:0] exc_pc;
  logic [XLEN-1:0] exc_val;
  logic            irq_pending;
  logic [4:0]      irq_code;
  logic [XLEN-1:0] irq_pc;
  logic            xret_valid;
  logic            xret_is_mret;
  logic [1:0]      current_priv;
  logic [15:0]     medeleg;
  logic [15:0]     mideleg;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] stvec;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] sepc;
  logic [1:0]      mpp;
  logic            spp;
  logic            redirect_ready;
  logic            busy;
  logic            pipe_stall;
  logic            pipe_flush;
  logic            trap_csr_we;
  logic            xret_csr_we;
  logic            trap_to_s;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_epc;
  logic [XLEN-1:0] trap_tval;
  logic            priv_we;
  logic [1:0]      priv_next;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trap_controller #(.XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_val(exc_val),
    .irq_pending(irq_pending), .irq_code(irq_code), .irq_pc(irq_pc),
    .xret_valid(xret_valid), .xret_is_mret(xret_is_mret), .current_priv(current_priv),
    .medeleg(medeleg), .mideleg(mideleg), .mtvec(mtvec), .stvec(stvec),
    .mepc(mepc), .sepc(sepc), .mpp(mpp), .spp(spp), .redirect_ready(redirect_ready),
    .busy(busy), .pipe_stall(pipe_stall), .pipe_flush(pipe_flush),
    .trap_csr_we(trap_csr_we), .xret_csr_we(xret_csr_we), .trap_to_s(trap_to_s),
    .trap_cause(trap_cause), .trap_epc(trap_epc), .trap_tval(trap_tval),
    .priv_we(priv_we), .priv_next(priv_next),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  task automatic clear_events();
    exc_valid   = 1'b0;
    irq_pending = 1'b0;
    xret_valid  = 1'b0;
  endtask

  task automatic clear_all();
    clear_events();
    exc_code = '0; exc_pc = '0; exc_val = '0;
    irq_code = '0; irq_pc = '0; xret_is_mret = 1'b0;
    current_priv = 2'b00; medeleg = '0; mideleg = '0;
    mtvec = '0; stvec = '0; mepc = '0; sepc = '0; mpp = 2'b00; spp = 1'b0;
    redirect_ready = 1'b1;
  endtask

  // Cross edge N with the currently driven event, then drop it; returns at the cycle N+1 sample point
  task automatic fire();
    @(posedge clk);
    @(negedge clk);
    clear_events();
  endtask

  task automatic test_reset();
    clear_all();
    reset_n = 1'b0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (priv_next !== 2'b11) begin errors++; $display("FAIL reset_priv_next got=%b exp=11", priv_next); end
    checks++; if ({pipe_stall, pipe_flush, trap_csr_we, xret_csr_we, priv_we, redirect_valid, trap_to_s} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0000000", {pipe_stall, pipe_flush, trap_csr_we, xret_csr_we, priv_we, redirect_valid, trap_to_s}); end
    checks++; if ((trap_cause | trap_epc | trap_tval | redirect_pc) !== 32'h0) begin
      errors++; $display("FAIL reset_data got=%h exp=0", trap_cause | trap_epc | trap_tval | redirect_pc); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ecall();
    exc_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h100; exc_val = 32'h0;
    current_priv = 2'b00; medeleg = 16'h0; mtvec = 32'h8000_0100; stvec = 32'h9000_0000;
    fire();
    checks++; if ({busy, pipe_stall, pipe_flush, trap_csr_we, redirect_valid} !== 5'b11100) begin
      errors++; $display("FAIL ecall_n1 got=%b exp=11100", {busy, pipe_stall, pipe_flush, trap_csr_we, redirect_valid}); end
    @(negedge clk);
    checks++; if ({pipe_flush, trap_csr_we, xret_csr_we, priv_we, redirect_valid} !== 5'b01010) begin
      errors++; $display("FAIL ecall_n2_ctrl got=%b exp=01010", {pipe_flush, trap_csr_we, xret_csr_we, priv_we, redirect_valid}); end
    checks++; if (trap_cause !== 32'd8) begin errors++; $display("FAIL ecall_cause got=%h exp=00000008", trap_cause); end
    checks++; if (trap_epc !== 32'h100) begin errors++; $display("FAIL ecall_epc got=%h exp=00000100", trap_epc); end
    checks++; if (trap_tval !== 32'h0) begin errors++; $display("FAIL ecall_tval got=%h exp=0", trap_tval); end
    checks++; if ({trap_to_s, priv_next} !== 3'b011) begin errors++; $display("FAIL ecall_priv got=%b exp=011", {trap_to_s, priv_next}); end
    @(negedge clk);
    checks++; if ({redirect_valid, trap_csr_we, priv_we, busy} !== 4'b1001) begin
      errors++; $display("FAIL ecall_n3_ctrl got=%b exp=1001", {redirect_valid, trap_csr_we, priv_we, busy}); end
    checks++; if (redirect_pc !== 32'h8000_0100) begin errors++; $display("FAIL ecall_redirect got=%h exp=80000100", redirect_pc); end
    @(negedge clk);
    checks++; if ({busy, pipe_stall, redirect_valid} !== 3'b000) begin
      errors++; $display("FAIL ecall_idle got=%b exp=000", {busy, pipe_stall, redirect_valid}); end
  endtask

  task automatic test_delegation();
    // From U with medeleg[13] set: goes to S, exception ignores vectored mode
    exc_valid = 1'b1; exc_code = 5'd13; exc_pc = 32'h400; exc_val = 32'h1234;
    current_priv = 2'b00; medeleg = 16'h2000; stvec = 32'h8000_2001; mtvec = 32'h8000_0100;
    fire();
    @(negedge clk);
    checks++; if ({trap_to_s, priv_next} !== 3'b101) begin errors++; $display("FAIL deleg_u_priv got=%b exp=101", {trap_to_s, priv_next}); end
    checks++; if (trap_tval !== 32'h1234) begin errors++; $display("FAIL deleg_u_tval got=%h exp=00001234", trap_tval); end
    checks++; if (trap_cause !== 32'd13) begin errors++; $display("FAIL deleg_u_cause got=%h exp=0000000d", trap_cause); end
    @(negedge clk);
    checks++; if (redirect_pc !== 32'h8000_2000) begin errors++; $display("FAIL deleg_u_redirect got=%h exp=80002000", redirect_pc); end
    @(negedge clk);
    // Same event from M is never delegated
    exc_valid = 1'b1; current_priv = 2'b11;
    fire();
    @(negedge clk);
    checks++; if ({trap_to_s, priv_next} !== 3'b011) begin errors++; $display("FAIL deleg_m_priv got=%b exp=011", {trap_to_s, priv_next}); end
    @(negedge clk);
    checks++; if (redirect_pc !== 32'h8000_0100) begin errors++; $display("FAIL deleg_m_redirect got=%h exp=80000100", redirect_pc); end
    @(negedge clk);
    current_priv = 2'b00; medeleg = '0;
  endtask

  task automatic test_vectored_irq();
    irq_pending = 1'b1; irq_code = 5'd7; irq_pc = 32'h200;
    mtvec = 32'h8000_0001; mideleg = 16'h0; current_priv = 2'b11; exc_val = 32'hdead;
    fire();
    checks++; if (trap_cause !== 32'h8000_0007) begin errors++; $display("FAIL irq_cause got=%h exp=80000007", trap_cause); end
    checks++; if (trap_epc !== 32'h200) begin errors++; $display("FAIL irq_epc got=%h exp=00000200", trap_epc); end
    checks++; if (trap_tval !== 32'h0) begin errors++; $display("FAIL irq_tval got=%h exp=0", trap_tval); end
    @(negedge clk);
    checks++; if ({trap_csr_we, priv_we, trap_to_s, priv_next} !== 5'b11011) begin
      errors++; $display("FAIL irq_commit got=%b exp=11011", {trap_csr_we, priv_we, trap_to_s, priv_next}); end
    @(negedge clk);
    checks++; if (redirect_pc !== 32'h8000_001c) begin errors++; $display("FAIL irq_redirect got=%h exp=8000001c", redirect_pc); end
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    // All three sources held for the whole sequence: only the exception runs
    exc_valid = 1'b1; exc_code = 5'd2; exc_pc = 32'h300; exc_val = 32'h0;
    irq_pending = 1'b1; irq_code = 5'd3; irq_pc = 32'h500;
    xret_valid = 1'b1; xret_is_mret = 1'b1; mepc = 32'h7000_0000;
    mtvec = 32'h8000_0100; current_priv = 2'b11;
    @(posedge clk);
    @(negedge clk);
    checks++; if (trap_cause !== 32'd2) begin errors++; $display("FAIL simul_cause got=%h exp=00000002", trap_cause); end
    @(negedge clk);
    checks++; if ({trap_csr_we, xret_csr_we} !== 2'b10) begin errors++; $display("FAIL simul_we got=%b exp=10", {trap_csr_we, xret_csr_we}); end
    @(negedge clk);
    checks++; if ({redirect_valid, pipe_flush, trap_epc} !== {2'b10, 32'h300}) begin
      errors++; $display("FAIL simul_redirect got=%b_%h exp=10_00000300", {redirect_valid, pipe_flush}, trap_epc); end
    checks++; if (redirect_pc !== 32'h8000_0100) begin errors++; $display("FAIL simul_pc got=%h exp=80000100", redirect_pc); end
    clear_events();
    @(negedge clk);
    // Exception arriving during COMMIT of an interrupt has no effect
    irq_pending = 1'b1; irq_code = 5'd11; irq_pc = 32'h600; mtvec = 32'h8000_0000;
    fire();
    exc_valid = 1'b1; exc_code = 5'd4;
    @(negedge clk);
    checks++; if (trap_cause !== 32'h8000_000b) begin errors++; $display("FAIL commit_exc_cause got=%h exp=8000000b", trap_cause); end
    @(negedge clk);
    clear_events();
    checks++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'h8000_0000}) begin
      errors++; $display("FAIL commit_exc_redirect got=%b_%h exp=1_80000000", redirect_valid, redirect_pc); end
    @(negedge clk);
    @(negedge clk);
    checks++; if ({busy, pipe_flush} !== 2'b00) begin errors++; $display("FAIL commit_exc_idle got=%b exp=00", {busy, pipe_flush}); end
  endtask

  task automatic test_returns();
    xret_valid = 1'b1; xret_is_mret = 1'b1; mepc = 32'h8000_0045; mpp = 2'b00; current_priv = 2'b11;
    fire();
    @(negedge clk);
    checks++; if ({xret_csr_we, trap_csr_we, priv_we} !== 3'b101) begin
      errors++; $display("FAIL mret_we got=%b exp=101", {xret_csr_we, trap_csr_we, priv_we}); end
    checks++; if ({trap_to_s, priv_next} !== 3'b000) begin errors++; $display("FAIL mret_priv got=%b exp=000", {trap_to_s, priv_next}); end
    @(negedge clk);
    checks++; if (redirect_pc !== 32'h8000_0044) begin errors++; $display("FAIL mret_redirect got=%h exp=80000044", redirect_pc); end
    @(negedge clk);
    xret_valid = 1'b1; xret_is_mret = 1'b0; sepc = 32'h8000_0101; spp = 1'b1; current_priv = 2'b01;
    fire();
    @(negedge clk);
    checks++; if ({xret_csr_we, trap_csr_we, trap_to_s, priv_next} !== 5'b10101) begin
      errors++; $display("FAIL sret_commit got=%b exp=10101", {xret_csr_we, trap_csr_we, trap_to_s, priv_next}); end
    @(negedge clk);
    checks++; if (redirect_pc !== 32'h8000_0100) begin errors++; $display("FAIL sret_redirect got=%h exp=80000100", redirect_pc); end
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    redirect_ready = 1'b0;
    exc_valid = 1'b1; exc_code = 5'd1; exc_pc = 32'h700; current_priv = 2'b11; mtvec = 32'h8000_0200;
    fire();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({redirect_valid, busy, pipe_stall, redirect_pc} !== {3'b111, 32'h8000_0200}) begin
        errors++; $display("FAIL stall_hold_%0d got=%b_%h exp=111_80000200", i, {redirect_valid, busy, pipe_stall}, redirect_pc); end
    end
    redirect_ready = 1'b1;
    @(negedge clk);
    checks++; if ({redirect_valid, busy} !== 2'b00) begin errors++; $display("FAIL stall_release got=%b exp=00", {redirect_valid, busy}); end
  endtask

  task automatic test_mid_reset();
    exc_valid = 1'b1; exc_code = 5'd5; exc_pc = 32'h900; exc_val = 32'h55; current_priv = 2'b00;
    fire();
    checks++; if (pipe_flush !== 1'b1) begin errors++; $display("FAIL midrst_flush got=%b exp=1", pipe_flush); end
    reset_n = 1'b0;
    #1;
    checks++; if ({busy, pipe_stall, pipe_flush, priv_next} !== 5'b00011) begin
      errors++; $display("FAIL midrst_ctrl got=%b exp=00011", {busy, pipe_stall, pipe_flush, priv_next}); end
    checks++; if ((trap_cause | trap_epc | trap_tval) !== 32'h0) begin
      errors++; $display("FAIL midrst_data got=%h exp=0", trap_cause | trap_epc | trap_tval); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({busy, pipe_flush, trap_csr_we, redirect_valid} !== 4'b0000) begin
      errors++; $display("FAIL midrst_no_retry got=%b exp=0000", {busy, pipe_flush, trap_csr_we, redirect_valid}); end
  endtask

  initial begin
    test_reset();
    test_ecall();
    test_delegation();
    test_vectored_irq();
    test_simultaneous();
    test_returns();
    test_back_pressure();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_controller.md
# trap_controller

Sequences trap entry and trap return for the RV1 core. Each cycle it takes one event from three sources: the prioritized exception from the exception detection unit, a pending interrupt, or a committed MRET/SRET. It then runs a fixed four-state sequence: pipeline flush, CSR/privilege commit, and fetch redirect through a ready handshake. It sits between exception detection, the CSR file and the PC/fetch unit, and is parameterized for RV32/RV64.

## Interface
- XLEN, default `XLEN, datapath width (32 or 64).

- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- exc_valid  in  1  exception present (level)
- exc_code  in  5  exception cause code
- exc_pc  in  XLEN  faulting instruction PC
- exc_val  in  XLEN  trap value
- irq_pending  in  1  enabled interrupt pending (already gated by mie/mstatus)
- irq_code  in  5  highest-priority interrupt cause
- irq_pc  in  XLEN  PC of next unretired instruction
- xret_valid  in  1  MRET/SRET committed (privilege already checked upstream)
- xret_is_mret  in  1  1 = MRET, 0 = SRET
- current_priv  in  2  current privilege mode (00 U, 01 S, 11 M)
- medeleg  in  16  exception delegation bits, codes 0–15
- mideleg  in  16  interrupt delegation bits, codes 0–15
- mtvec, stvec  in  XLEN  trap vectors; [1:0] is the mode (0 direct, 1 vectored)
- mepc, sepc  in  XLEN  return PCs
- mpp  in  2  mstatus.MPP
- spp  in  1  mstatus.SPP
- redirect_ready  in  1  fetch accepts the redirect
- busy  out  1  sequence in progress
- pipe_stall  out  1  hold all pipeline stages
- pipe_flush  out  1  kill IF/ID/EX/MEM contents
- trap_csr_we  out  1  write the trap CSRs (epc/cause/tval, push status stack)
- xret_csr_we  out  1  pop the status stack
- trap_to_s  out  1  1 = the write/pop targets the S-mode CSRs
- trap_cause  out  XLEN  bit XLEN-1 = interrupt; low 5 bits = code
- trap_epc  out  XLEN  value for xepc
- trap_tval  out  XLEN  value for xtval
- priv_we  out  1  update the privilege mode
- priv_next  out  2  new privilege mode
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  XLEN  redirect target

## Operation
The controller is a four-state FSM: IDLE, FLUSH, COMMIT, REDIRECT.

**IDLE**
- Event priority: exc_valid, then irq_pending, then xret_valid.
- When any event is present, latch its kind, code, PC, tval and the current CSR inputs, then go to FLUSH.
- The latched CSR inputs are the delegation bits, tvec, epc, mpp/spp and current_priv.
- With no event, remain in IDLE.

**Delegation (trap_to_s)**
- trap_to_s = (current_priv != 11) and code < 16 and deleg[code].
- deleg is medeleg for exceptions and mideleg for interrupts.
- For xret: trap_to_s = !xret_is_mret.

**Trap fields**
- Exception: trap_cause = zero-extended code; trap_epc = exc_pc; trap_tval = exc_val.
- Interrupt: trap_cause = {1, 0…, code}; trap_epc = irq_pc; trap_tval = 0.

**Trap target**
- tvec is stvec when trap_to_s is set, otherwise mtvec.
- base = tvec with bits [1:0] cleared.
- Target is base + (code << 2) for an interrupt with mode 01; otherwise base.
- Shift and add are XLEN wide; wrap-around is ignored.
- priv_next = 01 if trap_to_s, else 11.

**xret target**
- MRET: target = mepc & ~1, priv_next = mpp.
- SRET: target = sepc & ~1, priv_next = {0, spp}.

**FLUSH**
- Assert pipe_flush for one cycle, then go to COMMIT.

**COMMIT**
- Assert priv_we for one cycle.
- For a trap, also pulse trap_csr_we; for an xret, pulse xret_csr_we.
- Go to REDIRECT.

**REDIRECT**
- Hold redirect_valid and redirect_pc until redirect_valid && redirect_ready, then go to IDLE.

**General rules**
- All inputs are ignored outside IDLE, including new exceptions and interrupts.
- busy and pipe_stall are high in FLUSH, COMMIT and REDIRECT.

## Timing
- All outputs are registered and decoded from the state plus latched data.
- Reset (async assert, sync deassert):
  - state = IDLE;
  - every output 0, except priv_next = 11.
  - The same applies mid-sequence: the partial sequence is abandoned and nothing is retried.
- Event sampled in IDLE at edge N:
  - pipe_flush is high in cycle N+1;
  - the CSR/priv write pulses are high in cycle N+2;
  - redirect_valid is high from cycle N+3.
- Minimum latency from event to IDLE is 4 cycles; each cycle of redirect_ready low adds one.
- trap_cause, trap_epc, trap_tval, trap_to_s and priv_next are stable from FLUSH through REDIRECT.
- redirect_pc is stable while redirect_valid is high.
- The FSM returns to IDLE on the handshake edge; a new event can be sampled on the following edge.

## Test plan
- **ECALL, undelegated.** ECALL from U: code 8, exc_pc = 0x100, medeleg = 0, mtvec = 0x80000100 → pipe_flush at N+1; trap_csr_we at N+2 with cause 8, epc 0x100, tval 0, priv_next 11, trap_to_s 0; redirect 0x80000100 at N+3.
- **Delegated exception, vectored stvec.** current_priv = U, code 13, medeleg[13] = 1, stvec = 0x80002001, exc_val = 0x1234 → trap_to_s 1, tval 0x1234, priv_next 01, redirect 0x80002000 (exceptions are not vectored). Repeat with current_priv = M → trap_to_s 0 and the mtvec target.
- **Vectored interrupt.** irq_code 7, mtvec = 0x80000001, irq_pc = 0x200 → trap_cause 0x80000007 (RV32), epc 0x200, redirect 0x8000001C.
- **Simultaneous events.** exc_valid, irq_pending and xret_valid all high in IDLE → the exception sequence runs, and irq/xret are ignored until IDLE. Separately, a new exc_valid during COMMIT has no effect.
- **Returns.** MRET with mepc = 0x80000045, mpp = 00 → xret_csr_we pulse, no trap_csr_we, priv_next 00, redirect 0x80000044. SRET with spp = 1 → priv_next 01, trap_to_s 1.
- **Handshake stall and mid-sequence reset.** Hold redirect_ready low for 3 cycles → redirect_valid and redirect_pc are held, busy stays high, and IDLE is reached one edge after ready rises. Assert reset_n low during FLUSH → all outputs 0 immediately and priv_next = 11.
